// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    // Instruction classes; each class shares one path through the FSM.
    typedef enum logic [3:0] {
        C_NOP, C_RALU, C_IMM, C_MFHL, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_MD
    } iclass_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_XOR  = 6'h26;

    localparam logic [4:0] RT_BNEZALC = 5'b10011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;

    localparam logic [2:0] EXT_ZERO = 3'b000;
    localparam logic [2:0] EXT_SIGN = 3'b001;
    localparam logic [2:0] EXT_LUI  = 3'b010;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [2:0] M2R_ALU   = 3'b000;
    localparam logic [2:0] M2R_WORD  = 3'b001;
    localparam logic [2:0] M2R_LUI   = 3'b010;
    localparam logic [2:0] M2R_LINK  = 3'b011;
    localparam logic [2:0] M2R_BYTE  = 3'b100;
    localparam logic [2:0] M2R_HI    = 3'b101;
    localparam logic [2:0] M2R_LO    = 3'b110;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b100;

    // Decoded fields for the instruction currently held in IR.
    typedef struct packed {
        iclass_t    cls;
        logic [2:0] alu;
        logic       alu_src;
        logic [2:0] ext;
        logic [1:0] reg_dst;
        logic [2:0] mem2reg;
        logic [2:0] npc;
        logic       link;     // writes PC register into a GPR
        logic       cond;     // PC update enable for branch/jump class
        logic       md_op;    // 0 mult, 1 div
    } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and comparator flags in,
// per-state enables and unit controls out. Everything is level-based,
// there is no handshake: the controller owns sequencing and the datapath
// obeys the enables in the cycle they are asserted.
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt;
    logic             eq;
    logic             rs_gtz;
    logic             rs_nez;
    logic             PCWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic             MemRead;
    logic [2:0]       ALUControl;
    logic             ALUSrc;
    logic [2:0]       EXTControl;
    logic [1:0]       RegDst;
    logic [2:0]       Mem2Reg;
    logic [2:0]       NPCControl;
    logic             md_start;
    logic             md_op;
    logic             md_busy;
    logic [2:0]       state;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, rt, eq, rs_gtz, rs_nez,
        output PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
        output ALUControl, ALUSrc, EXTControl, RegDst, Mem2Reg, NPCControl,
        output md_start, md_op, md_busy, state, instr_done, instr_count
    );

    modport slave (
        output opcode, funct, rt, eq, rs_gtz, rs_nez,
        input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
        input  ALUControl, ALUSrc, EXTControl, RegDst, Mem2Reg, NPCControl,
        input  md_start, md_op, md_busy, state, instr_done, instr_count
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of IR fields into instruction class and unit controls.
module instr_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       eq,
    input  logic       rs_gtz,
    input  logic       rs_nez,
    output dec_t       dec
);

    // Class and field decode; anything unlisted stays a NOP.
    always_comb begin
        dec         = '0;
        dec.cls     = C_NOP;
        dec.ext     = EXT_ZERO;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin dec.cls = C_RALU; dec.alu = ALU_ADD; dec.reg_dst = RD_RD; end
                    FN_SUB:  begin dec.cls = C_RALU; dec.alu = ALU_SUB; dec.reg_dst = RD_RD; end
                    FN_XOR:  begin dec.cls = C_RALU; dec.alu = ALU_XOR; dec.reg_dst = RD_RD; end
                    FN_SLL:  begin dec.cls = C_RALU; dec.alu = ALU_SLL; dec.reg_dst = RD_RD; end
                    FN_JR:   begin dec.cls = C_JUMP; dec.npc = NPC_JR; dec.cond = 1'b1; end
                    FN_JALR: begin
                        dec.cls = C_JUMP; dec.npc = NPC_JR; dec.cond = 1'b1;
                        dec.link = 1'b1; dec.reg_dst = RD_RD; dec.mem2reg = M2R_LINK;
                    end
                    FN_MULT: begin dec.cls = C_MD; dec.md_op = 1'b0; end
                    FN_DIV:  begin dec.cls = C_MD; dec.md_op = 1'b1; end
                    FN_MFHI: begin dec.cls = C_MFHL; dec.reg_dst = RD_RD; dec.mem2reg = M2R_HI; end
                    FN_MFLO: begin dec.cls = C_MFHL; dec.reg_dst = RD_RD; dec.mem2reg = M2R_LO; end
                    default: ;
                endcase
            end
            OP_ORI:  begin dec.cls = C_IMM; dec.alu = ALU_OR;  dec.alu_src = 1'b1; dec.ext = EXT_ZERO; end
            OP_ADDI: begin dec.cls = C_IMM; dec.alu = ALU_ADD; dec.alu_src = 1'b1; dec.ext = EXT_SIGN; end
            OP_LUI:  begin
                dec.cls = C_IMM; dec.alu = ALU_ADD; dec.alu_src = 1'b1; dec.ext = EXT_LUI;
                dec.mem2reg = M2R_LUI;
            end
            OP_LW:   begin dec.cls = C_LOAD;  dec.alu_src = 1'b1; dec.ext = EXT_SIGN; dec.mem2reg = M2R_WORD; end
            OP_LB:   begin dec.cls = C_LOAD;  dec.alu_src = 1'b1; dec.ext = EXT_SIGN; dec.mem2reg = M2R_BYTE; end
            OP_SW,
            OP_SB:   begin dec.cls = C_STORE; dec.alu_src = 1'b1; dec.ext = EXT_SIGN; end
            OP_BEQ:  begin
                dec.cls = C_BRANCH; dec.alu = ALU_SUB; dec.ext = EXT_SIGN; dec.npc = NPC_BR; dec.cond = eq;
            end
            OP_BGTZ: begin
                dec.cls = C_BRANCH; dec.alu = ALU_SUB; dec.ext = EXT_SIGN; dec.npc = NPC_BR; dec.cond = rs_gtz;
            end
            OP_REGIMM: begin
                if (rt == RT_BNEZALC) begin
                    dec.cls = C_BRANCH; dec.alu = ALU_SUB; dec.ext = EXT_SIGN; dec.npc = NPC_BR;
                    dec.cond = rs_nez; dec.link = 1'b1; dec.reg_dst = RD_RA; dec.mem2reg = M2R_LINK;
                end
            end
            OP_J:    begin dec.cls = C_JUMP; dec.npc = NPC_J; dec.cond = 1'b1; end
            OP_JAL:  begin
                dec.cls = C_JUMP; dec.npc = NPC_J; dec.cond = 1'b1;
                dec.link = 1'b1; dec.reg_dst = RD_RA; dec.mem2reg = M2R_LINK;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB/MDWAIT sequencing,
// mult/div busy wait and retired-instruction counter.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MD_LAT = 5,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    dec_t             dec;
    state_t           state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] count_q;

    logic       pc_write, ir_write, reg_write, mem_write, mem_read;
    logic [2:0] alu_ctrl, ext_ctrl, mem2reg, npc_ctrl;
    logic       alu_src, md_start, md_op, md_busy, done;
    logic [1:0] reg_dst;

    instr_decoder u_dec (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .rt     (bus.rt),
        .eq     (bus.eq),
        .rs_gtz (bus.rs_gtz),
        .rs_nez (bus.rs_nez),
        .dec    (dec)
    );

    // State, mult/div wait counter and retired count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            md_cnt_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (done) count_q <= count_q + CNT_W'(1);
        end
    end

    // Next state and per-state controls; everything held low during reset.
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        alu_ctrl  = ALU_ADD;
        alu_src   = 1'b0;
        ext_ctrl  = EXT_ZERO;
        reg_dst   = RD_RT;
        mem2reg   = M2R_ALU;
        npc_ctrl  = NPC_SEQ;
        md_start  = 1'b0;
        md_op     = 1'b0;
        md_busy   = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            // ALU/EXT selects stay applied for every datapath-using state.
            if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                alu_ctrl = dec.alu;
                alu_src  = dec.alu_src;
                ext_ctrl = dec.ext;
            end
            case (state_q)
                S_FETCH: begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
                S_DECODE: begin
                    if (dec.cls == C_NOP) begin
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (dec.cls)
                        C_RALU, C_IMM, C_MFHL: state_d = S_WB;
                        C_LOAD, C_STORE:       state_d = S_MEM;
                        C_BRANCH, C_JUMP: begin
                            // Link uses the PC register, which already holds PC+4.
                            pc_write = dec.cond;
                            npc_ctrl = dec.npc;
                            if (dec.link) begin
                                reg_write = 1'b1;
                                reg_dst   = dec.reg_dst;
                                mem2reg   = dec.mem2reg;
                            end
                            done    = 1'b1;
                            state_d = S_FETCH;
                        end
                        C_MD: begin
                            md_start = 1'b1;
                            md_op    = dec.md_op;
                            md_cnt_d = MD_LOAD;
                            state_d  = S_MDWAIT;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dec.cls == C_LOAD) begin
                        mem_read = 1'b1;
                        state_d  = S_WB;
                    end else begin
                        mem_write = 1'b1;
                        done      = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = dec.reg_dst;
                    mem2reg   = dec.mem2reg;
                    done      = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MDWAIT: begin
                    md_busy = 1'b1;
                    if (md_cnt_q == 4'd0) begin
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        md_cnt_d = md_cnt_q - 4'd1;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IRWrite     = ir_write;
    assign bus.RegWrite    = reg_write;
    assign bus.MemWrite    = mem_write;
    assign bus.MemRead     = mem_read;
    assign bus.ALUControl  = alu_ctrl;
    assign bus.ALUSrc      = alu_src;
    assign bus.EXTControl  = ext_ctrl;
    assign bus.RegDst      = reg_dst;
    assign bus.Mem2Reg     = mem2reg;
    assign bus.NPCControl  = npc_ctrl;
    assign bus.md_start    = md_start;
    assign bus.md_op       = md_op;
    assign bus.md_busy     = md_busy;
    assign bus.state       = state_q;
    assign bus.instr_done  = done;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle expected control vectors built from
// instruction-level cycle rules, random program plus directed cases.
module tb_mc_controller;

  localparam int MD_LAT = 5;
  localparam int CNT_W  = 4;   // narrow so the counter wraps within the run

  localparam int K_NOP = 0, K_WB = 1, K_LOAD = 2, K_STORE = 3, K_CTRL = 4, K_MD = 5;

  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic [4:0] rt; int kind; logic chk;
    logic [2:0] alu; logic asrc; logic [2:0] ext; logic [1:0] rd; logic [2:0] m2r;
    logic [2:0] npc; int cs; logic link; logic mop;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ins_t tbl[32];
  int n_tbl = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [CNT_W-1:0] model_count = '0;
  logic cur_e, cur_g, cur_z;
  logic [19:0] exp_q[$];

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_controller #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [2:0] st, input logic pcw, irw, rw, mw, mr,
                                     input logic [2:0] npc, input logic [1:0] rd, input logic [2:0] m2r,
                                     input logic ms, mb, mo, dn);
    return {st, pcw, irw, rw, mw, mr, npc, rd, m2r, ms, mb, mo, dn};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead,
            bus.NPCControl, bus.RegDst, bus.Mem2Reg, bus.md_start, bus.md_busy, bus.md_op,
            bus.instr_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic def(input logic [5:0] op, fn, input logic [4:0] rt, input int kind, input logic chkf,
                     input logic [2:0] alu, input logic asrc, input logic [2:0] ext, input logic [1:0] rd,
                     input logic [2:0] m2r, npc, input int cs, input logic link, mop);
    tbl[n_tbl] = '{op, fn, rt, kind, chkf, alu, asrc, ext, rd, m2r, npc, cs, link, mop};
    n_tbl++;
  endtask

  // Present instruction k in IR while the controller is in FETCH.
  task automatic drive(input int k);
    bus.opcode = tbl[k].op;
    bus.funct  = (tbl[k].op == 6'h00) ? tbl[k].fn : 6'($urandom);
    bus.rt     = (tbl[k].op == 6'h01) ? tbl[k].rt : 5'($urandom);
    bus.eq     = cur_e;
    bus.rs_gtz = cur_g;
    bus.rs_nez = cur_z;
  endtask

  task automatic step(input logic [19:0] ev, input int k);
    @(negedge clk);
    chk("ctl", 32'(obs()), 32'(ev));
    chk("cnt", 32'(bus.instr_count), 32'(model_count));
    if (ev[19:17] == 3'd2 && tbl[k].chk)
      chk("alu", {25'd0, bus.EXTControl, bus.ALUSrc, bus.ALUControl},
          {25'd0, tbl[k].ext, tbl[k].asrc, tbl[k].alu});
    if (ev[19:17] == 3'd0) drive(k);
    if (ev[0]) model_count++;
  endtask

  // Reference: expected cycle sequence of one instruction from its class.
  task automatic run_instr(input int k, input logic e, g, z);
    logic taken;
    ins_t t;
    t = tbl[k];
    cur_e = e; cur_g = g; cur_z = z;
    taken = (t.cs == 0) ? 1'b1 : (t.cs == 1) ? e : (t.cs == 2) ? g : z;
    exp_q.push_back(mk(3'd0, 1, 1, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0));
    exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, t.kind == K_NOP));
    case (t.kind)
      K_WB: begin
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(3'd4, 0, 0, 1, 0, 0, 3'd0, t.rd, t.m2r, 0, 0, 0, 1));
      end
      K_LOAD: begin
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 1, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(3'd4, 0, 0, 1, 0, 0, 3'd0, t.rd, t.m2r, 0, 0, 0, 1));
      end
      K_STORE: begin
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0));
        exp_q.push_back(mk(3'd3, 0, 0, 0, 1, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 1));
      end
      K_CTRL:
        exp_q.push_back(mk(3'd2, taken, 0, t.link, 0, 0, t.npc, t.link ? t.rd : 2'd0,
                           t.link ? t.m2r : 3'd0, 0, 0, 0, 1));
      K_MD: begin
        exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 1, 0, t.mop, 0));
        for (int i = 0; i < MD_LAT; i++)
          exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 1, 0, i == MD_LAT - 1));
      end
      default: ;
    endcase
    while (exp_q.size() > 0) step(exp_q.pop_front(), k);
  endtask

  initial begin
    //   op     fn    rt     kind     chk alu  src ext  rd   m2r  npc  cs link mop
    def(6'h00, 6'h20, 5'd0, K_WB,    1, 3'd0, 0, 3'd0, 2'd1, 3'd0, 3'd0, 0, 0, 0); // 0 add
    def(6'h00, 6'h22, 5'd0, K_WB,    1, 3'd1, 0, 3'd0, 2'd1, 3'd0, 3'd0, 0, 0, 0); // 1 sub
    def(6'h00, 6'h26, 5'd0, K_WB,    1, 3'd2, 0, 3'd0, 2'd1, 3'd0, 3'd0, 0, 0, 0); // 2 xor
    def(6'h00, 6'h00, 5'd0, K_WB,    1, 3'd4, 0, 3'd0, 2'd1, 3'd0, 3'd0, 0, 0, 0); // 3 sll
    def(6'h00, 6'h08, 5'd0, K_CTRL,  0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd4, 0, 0, 0); // 4 jr
    def(6'h00, 6'h09, 5'd0, K_CTRL,  0, 3'd0, 0, 3'd0, 2'd1, 3'd3, 3'd4, 0, 1, 0); // 5 jalr
    def(6'h00, 6'h18, 5'd0, K_MD,    0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 6 mult
    def(6'h00, 6'h1A, 5'd0, K_MD,    0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 0, 0, 1); // 7 div
    def(6'h00, 6'h10, 5'd0, K_WB,    0, 3'd0, 0, 3'd0, 2'd1, 3'd5, 3'd0, 0, 0, 0); // 8 mfhi
    def(6'h00, 6'h12, 5'd0, K_WB,    0, 3'd0, 0, 3'd0, 2'd1, 3'd6, 3'd0, 0, 0, 0); // 9 mflo
    def(6'h0D, 6'h00, 5'd0, K_WB,    1, 3'd3, 1, 3'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 10 ori
    def(6'h08, 6'h00, 5'd0, K_WB,    1, 3'd0, 1, 3'd1, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 11 addi
    def(6'h0F, 6'h00, 5'd0, K_WB,    1, 3'd0, 1, 3'd2, 2'd0, 3'd2, 3'd0, 0, 0, 0); // 12 lui
    def(6'h23, 6'h00, 5'd0, K_LOAD,  1, 3'd0, 1, 3'd1, 2'd0, 3'd1, 3'd0, 0, 0, 0); // 13 lw
    def(6'h20, 6'h00, 5'd0, K_LOAD,  1, 3'd0, 1, 3'd1, 2'd0, 3'd4, 3'd0, 0, 0, 0); // 14 lb
    def(6'h2B, 6'h00, 5'd0, K_STORE, 1, 3'd0, 1, 3'd1, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 15 sw
    def(6'h28, 6'h00, 5'd0, K_STORE, 1, 3'd0, 1, 3'd1, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 16 sb
    def(6'h04, 6'h00, 5'd0, K_CTRL,  1, 3'd1, 0, 3'd1, 2'd0, 3'd0, 3'd1, 1, 0, 0); // 17 beq
    def(6'h07, 6'h00, 5'd0, K_CTRL,  1, 3'd1, 0, 3'd1, 2'd0, 3'd0, 3'd1, 2, 0, 0); // 18 bgtz
    def(6'h02, 6'h00, 5'd0, K_CTRL,  0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd2, 0, 0, 0); // 19 j
    def(6'h03, 6'h00, 5'd0, K_CTRL,  0, 3'd0, 0, 3'd0, 2'd2, 3'd3, 3'd2, 0, 1, 0); // 20 jal
    def(6'h01, 6'h00, 5'h13, K_CTRL, 1, 3'd1, 0, 3'd1, 2'd2, 3'd3, 3'd1, 3, 1, 0); // 21 bnezalc
    def(6'h3F, 6'h00, 5'd0, K_NOP,   0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 22 bad opcode
    def(6'h00, 6'h3F, 5'd0, K_NOP,   0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 23 bad funct
    def(6'h01, 6'h00, 5'd0, K_NOP,   0, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 0, 0, 0); // 24 regimm other

    bus.opcode = '0; bus.funct = '0; bus.rt = '0;
    bus.eq = 1'b0; bus.rs_gtz = 1'b0; bus.rs_nez = 1'b0;

    // reset: outputs quiet while asserted, state FETCH afterwards
    @(negedge clk);
    chk("rst_ctl", 32'(obs()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0)));
    chk("rst_cnt", 32'(bus.instr_count), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // directed: lw, beq not taken/taken, bnezalc not taken, mult, bad opcode
    run_instr(13, 0, 0, 0);
    run_instr(17, 0, 0, 0);
    run_instr(17, 1, 0, 0);
    run_instr(21, 1, 1, 0);
    run_instr(6, 0, 0, 0);
    run_instr(22, 1, 1, 1);

    // reset in DECODE of add
    cur_e = 0; cur_g = 0; cur_z = 0;
    @(negedge clk); drive(0);
    @(negedge clk);
    chk("pre_rst_state", 32'(bus.state), 32'd1);
    reset = 1'b1;
    #1 chk("rst_dec_ctl", 32'(obs()), 32'(mk(3'd1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    chk("rst_dec_after", 32'(obs()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0)));
    chk("rst_dec_cnt", 32'(bus.instr_count), 32'd0);
    reset = 1'b0;
    model_count = '0;

    // random program, long enough to wrap the counter
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, n_tbl - 1), 1'($urandom), 1'($urandom), 1'($urandom));

    // reset during MDWAIT abandons the divide without a completion
    cur_e = 0; cur_g = 0; cur_z = 0;
    @(negedge clk); drive(7);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mdwait_busy", 32'(obs()), 32'(mk(3'd5, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 1, 0, 0)));
    reset = 1'b1;
    #1 chk("rst_md_ctl", 32'(obs()), 32'(mk(3'd5, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    chk("rst_md_after", 32'(obs()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 3'd0, 0, 0, 0, 0)));
    chk("rst_md_cnt", 32'(bus.instr_count), 32'd0);
    reset = 1'b0;
    model_count = '0;

    run_instr(7, 0, 0, 0);
    run_instr(20, 0, 0, 0);
    run_instr(14, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle MIPS controller: decodes the instruction held in IR and sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB, issuing per-state enables instead of one-cycle control. Adds multiply/divide sequencing with a parametrised busy wait, per-instruction completion pulses and a retired-instruction counter. Sits between IR/comparator outputs and the PC, IR, GRF, DM, ALU, EXT and HI/LO units of the multi-cycle CPU.

## Interface
- MD_LAT, 5: mult/div execution cycles (1..15).
- CNT_W, 32: retired-instruction counter width.
- clk  in  1  clock.
- reset  in  1  reset; one clock, synchronous, active-high.
- opcode  in  6  IR[31:26]; funct in 6 IR[5:0]; rt in 5 IR[20:16].
- eq  in  1  GPR[rs]==GPR[rt]; rs_gtz in 1 GPR[rs]>0 signed; rs_nez in 1 GPR[rs]!=0.
- PCWrite, IRWrite, RegWrite, MemWrite, MemRead  out  1  datapath enables.
- ALUControl  out  3  000 add, 001 sub, 010 xor, 011 or, 100 sll.
- ALUSrc  out  1  1 = extended immediate.
- EXTControl  out  3  000 zero, 001 sign, 010 lui-shift.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- Mem2Reg  out  3  000 ALU, 001 mem word, 010 lui, 011 link (PC reg), 100 mem byte, 101 HI, 110 LO.
- NPCControl  out  3  000 PC+4, 001 branch, 010 j/jal, 100 jr/jalr.
- md_start  out  1  one-cycle start to HI/LO unit; md_op out 1 0 mult, 1 div.
- md_busy  out  1  high in MDWAIT.
- state  out  3  current state encoding.
- instr_done  out  1  pulse in last cycle of each instruction.
- instr_count  out  CNT_W  retired instructions, wraps.

## Operation
- Decoded set: add, sub, xor, sll, jr, jalr, mult(011000), div(011010), mfhi(010000), mflo(010010), ori, addi, lui, lw, lb, sw, sb, beq, bgtz, j, jal, bnezalc (opcode 000001, rt 10011). Others = NOP.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5.
- FETCH: IRWrite=1, PCWrite=1, NPCControl=000; -> DECODE.
- DECODE: no enables. NOP -> FETCH with instr_done; else -> EXEC.
- EXEC: ALU/EXT controls per instruction (existing encodings).
  - R-ALU, ori, addi, lui, mfhi, mflo -> WB.
  - lw/lb/sw/sb: address compute -> MEM.
  - beq (eq), bgtz (rs_gtz), bnezalc (rs_nez): PCWrite=condition, NPCControl=001; -> FETCH, instr_done.
  - j: PCWrite, 010. jal: PCWrite, 010, RegWrite, RegDst=10, Mem2Reg=011. jr: PCWrite, 100. jalr: PCWrite, 100, RegWrite, RegDst=01, Mem2Reg=011. All -> FETCH, instr_done.
  - bnezalc: RegWrite, RegDst=10, Mem2Reg=011 unconditionally (link even if not taken).
  - mult/div: md_start=1, md_op set, counter loads MD_LAT-1 -> MDWAIT.
- MEM: lw/lb MemRead=1 -> WB; sw/sb MemWrite=1 -> FETCH, instr_done.
- WB: RegWrite=1 with RegDst/Mem2Reg per instruction; -> FETCH, instr_done.
- MDWAIT: md_busy=1; counter decrements; at 0 -> FETCH, instr_done.
- instr_count increments on every instr_done cycle (NOPs included); wraps at 2^CNT_W.

## Timing
- Outputs combinational from state and IR fields; state, counter and instr_count registered on clk.
- Cycles per instruction: NOP 2; branch/jump 3; sw/sb, R-ALU, imm, mfhi/mflo 4; lw/lb 5; mult/div 3+MD_LAT.
- Link value is PC register (already PC+4) sampled in the same cycle PC updates.
- Reset high: all enables, md_start, md_busy, instr_done = 0; state, MDWAIT counter and instr_count cleared next edge; state=FETCH after release. Reset mid-MDWAIT abandons wait, no instr_done.
- IR stable from DECODE through the final state (IRWrite only in FETCH).

## Structure
- mc_ctrl_pkg: state enum, opcode/funct constants, ALUControl/EXTControl/RegDst/Mem2Reg/NPCControl encodings.
- Sub-module instr_decoder: combinational class/field decode feeding FSM.

## Test plan
- Reset mid-DECODE of add -> next cycle state=0, RegWrite=0, instr_count=0.
- lw after reset -> states 0,1,2,3,4; MemRead only in MEM; RegWrite, Mem2Reg=001 in WB; instr_count=1.
- beq with eq=0 then eq=1 -> PCWrite=0 then PCWrite=1, NPCControl=001 in EXEC; each 3 cycles.
- bnezalc rs_nez=0 -> PCWrite=0, RegWrite=1, RegDst=10, Mem2Reg=011.
- mult with MD_LAT=5 -> md_start one cycle, md_busy 5 cycles, instr_done at cycle 8.
- Opcode 111111 -> 2-cycle NOP, no write enables outside FETCH, instr_count+1.
